// File: rtl/decode_issue.sv
// Issue stage behind the decoder: 2-entry skid buffer, immediate generation and
// serialization of fences and traps once the back end has drained.
module decode_issue #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned EXC_ILLEGAL = 2,
  parameter int unsigned EXC_BREAK   = 3,
  parameter int unsigned EXC_ECALL   = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [14:0]     in_decode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_unit,
  output logic [2:0]      out_sub_unit,
  output logic [3:0]      out_sel,
  output logic            out_use_imm,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_pc,
  input  logic            pipe_empty,
  output logic            fence_pulse,
  output logic            fence_i,
  output logic            exc_valid,
  output logic [3:0]      exc_cause,
  output logic [XLEN-1:0] exc_pc,
  input  logic            exc_ack
);

  localparam int unsigned REG_W   = 5;
  localparam int unsigned CAUSE_W = 4;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [1:0] unit;
    logic [2:0] sub_unit;
    logic [3:0] sel;
    logic       imm;
    logic       csr;
    logic       fence;
    logic       ecall;
    logic       ebreak;
    logic       illegal;
  } dec_t;

  typedef struct packed {
    dec_t             dec;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
  } entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t state, state_n;
  entry_t head, head_n, skid, skid_n, new_entry;
  logic   head_v, head_v_n, skid_v, skid_v_n;
  logic   in_ready_n, accept, pop;
  logic   head_ser, head_fence;

  // Immediate extraction by major opcode
  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] ins, input logic imm_bit);
    logic [XLEN-1:0] r;
    r = '0;
    case (ins[6:0])
      OP_IMM, OP_LOAD, OP_JALR: r = XLEN'($signed(ins[31:20]));
      OP_STORE:  r = XLEN'($signed({ins[31:25], ins[11:7]}));
      OP_BRANCH: r = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      OP_LUI, OP_AUIPC: r = XLEN'($signed({ins[31:12], 12'b0}));
      OP_JAL:    r = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      OP_SYSTEM: r = imm_bit ? XLEN'(ins[19:15]) : '0;
      default:   r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    new_entry.dec = dec_t'(in_decode);
    new_entry.rs1 = in_instr[19:15];
    new_entry.rs2 = in_instr[24:20];
    new_entry.rd  = in_instr[11:7];
    new_entry.pc  = in_pc;
    new_entry.imm = gen_imm(in_instr, in_decode[5]);
  end

  assign head_ser   = head_v & (head.dec.fence | head.dec.ecall | head.dec.ebreak | head.dec.illegal);
  assign head_fence = head.dec.fence & ~(head.dec.ecall | head.dec.ebreak | head.dec.illegal);
  assign accept     = in_valid & in_ready & ~flush;

  // Next state and handshake/pulse outputs; flush squashes everything this cycle
  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    out_valid   = 1'b0;
    fence_pulse = 1'b0;
    exc_valid   = 1'b0;
    unique case (state)
      RUN: begin
        if (head_ser) begin
          state_n = DRAIN;
        end else if (head_v) begin
          out_valid = 1'b1;
          pop       = out_ready;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          if (head_fence) begin
            fence_pulse = 1'b1;
            pop         = 1'b1;
            state_n     = RUN;
          end else begin
            state_n = TRAP;
          end
        end
      end
      TRAP: begin
        exc_valid = 1'b1;
        if (exc_ack) begin
          pop     = 1'b1;
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
    if (flush) begin
      state_n     = RUN;
      pop         = 1'b0;
      out_valid   = 1'b0;
      fence_pulse = 1'b0;
      exc_valid   = 1'b0;
    end
  end

  // Skid buffer update: skid only fills when the head is held and a new word arrives
  always_comb begin
    head_v_n = head_v;
    head_n   = head;
    skid_v_n = skid_v;
    skid_n   = skid;
    if (flush) begin
      head_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else if (pop) begin
      if (skid_v) begin
        head_n   = skid;
        skid_v_n = 1'b0;
      end else begin
        head_v_n = accept;
        if (accept) head_n = new_entry;
      end
    end else if (!head_v) begin
      head_v_n = accept;
      if (accept) head_n = new_entry;
    end else if (accept) begin
      skid_v_n = 1'b1;
      skid_n   = new_entry;
    end
  end

  assign in_ready_n = ~skid_v_n & (state_n == RUN) & ~flush;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_v   <= 1'b0;
      skid_v   <= 1'b0;
      head     <= '0;
      skid     <= '0;
      in_ready <= 1'b0;
    end else begin
      head_v   <= head_v_n;
      skid_v   <= skid_v_n;
      head     <= head_n;
      skid     <= skid_n;
      in_ready <= in_ready_n;
    end
  end

  assign out_unit     = head.dec.csr ? 2'd2 : head.dec.unit;
  assign out_sub_unit = head.dec.sub_unit;
  assign out_sel      = head.dec.sel;
  assign out_use_imm  = head.dec.imm;
  assign out_imm      = head.imm;
  assign out_rs1      = head.rs1;
  assign out_rs2      = head.rs2;
  assign out_rd       = head.rd;
  assign out_pc       = head.pc;
  assign fence_i      = fence_pulse & head.dec.imm;

  // Cause priority: illegal, then ebreak, then ecall
  always_comb begin
    exc_cause = '0;
    exc_pc    = '0;
    if (exc_valid) begin
      exc_pc = head.pc;
      if (head.dec.illegal)     exc_cause = CAUSE_W'(EXC_ILLEGAL);
      else if (head.dec.ebreak) exc_cause = CAUSE_W'(EXC_BREAK);
      else                      exc_cause = CAUSE_W'(EXC_ECALL);
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed cases with literal expectations, then random traffic
// checked every cycle against a queue-based reference model.
module tb_decode_issue;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_use_imm;
  logic        pipe_empty, fence_pulse, fence_i, exc_valid, exc_ack;
  logic [31:0] in_instr, in_pc, out_imm, out_pc, exc_pc;
  logic [14:0] in_decode;
  logic [1:0]  out_unit;
  logic [2:0]  out_sub_unit;
  logic [3:0]  out_sel, exc_cause;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc), .in_decode(in_decode),
    .out_valid(out_valid), .out_ready(out_ready), .out_unit(out_unit), .out_sub_unit(out_sub_unit),
    .out_sel(out_sel), .out_use_imm(out_use_imm), .out_imm(out_imm), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_pc(out_pc), .pipe_empty(pipe_empty),
    .fence_pulse(fence_pulse), .fence_i(fence_i), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_ack(exc_ack)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [14:0] dec;
  } ins_t;

  ins_t q[$];
  int   mode;   // 0 issuing, 1 waiting for back end to drain, 2 trap raised
  bit   rdy;
  bit   live;
  int   checks, failures;

  logic        s_in_ready, s_out_valid, s_use_imm, s_fence, s_fence_i, s_exc, s_acc;
  logic [1:0]  s_unit;
  logic [2:0]  s_sub;
  logic [3:0]  s_sel, s_cause;
  logic [4:0]  s_rd, s_rs1, s_rs2;
  logic [31:0] s_imm, s_exc_pc;

  logic [4:0]  issued[$];
  int          sent, fp_cnt, fi_cnt, ov_cnt;
  bit          ordy_k;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w, input logic imm_bit);
    logic [31:0] v;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: v = {{20{w[31]}}, w[31:20]};
      7'h23: v = {{20{w[31]}}, w[31:25], w[11:7]};
      7'h63: v = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'h37, 7'h17: v = {w[31:12], 12'h000};
      7'h6f: v = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      7'h73: v = imm_bit ? {27'h0, w[19:15]} : 32'h0;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h13;
      1: w[6:0] = 7'h03;
      2: w[6:0] = 7'h67;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;
      7: w[6:0] = 7'h6f;
      8: w[6:0] = 7'h73;
      default: ;
    endcase
    return w;
  endfunction

  function automatic logic [14:0] rand_dec();
    logic [14:0] d;
    d    = 15'($urandom) & 15'h7FE0;
    d[4] = ($urandom_range(0, 4) == 0);
    case ($urandom_range(0, 19))
      0: d[3] = 1'b1;
      1: d[2] = 1'b1;
      2: d[1] = 1'b1;
      3: d[0] = 1'b1;
      4: d[2:0] = 3'($urandom_range(1, 7));
      default: ;
    endcase
    return d;
  endfunction

  // One clock: drive at negedge, compare against the model, then advance the model
  task automatic cycle(input bit rst, input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [14:0] dec, input bit ordy, input bit pe, input bit ack, input bit fl);
    ins_t h;
    bit has, ser, fen, ov, fp, ev, pop, acc;
    logic [3:0] cause;
    @(negedge clk);
    reset = rst; in_valid = iv; in_instr = ins; in_pc = pc; in_decode = dec;
    out_ready = ordy; pipe_empty = pe; exc_ack = ack; flush = fl;
    #1;
    has = (q.size() > 0);
    h.instr = '0; h.pc = '0; h.dec = '0;
    if (has) h = q[0];
    ser   = has && (h.dec[3:0] != 4'h0);
    fen   = has && h.dec[3] && (h.dec[2:0] == 3'h0);
    ov    = !fl && mode == 0 && has && !ser;
    fp    = !fl && mode == 1 && pe && fen;
    ev    = !fl && mode == 2;
    cause = h.dec[0] ? 4'd2 : (h.dec[1] ? 4'd3 : 4'd11);

    s_in_ready = in_ready; s_out_valid = out_valid; s_use_imm = out_use_imm;
    s_fence = fence_pulse; s_fence_i = fence_i; s_exc = exc_valid; s_cause = exc_cause;
    s_unit = out_unit; s_sub = out_sub_unit; s_sel = out_sel; s_rd = out_rd; s_rs1 = out_rs1;
    s_rs2 = out_rs2; s_imm = out_imm; s_exc_pc = exc_pc;
    s_acc = iv && in_ready && !fl;

    if (live) begin
      chk("in_ready", in_ready, rdy);
      chk("out_valid", out_valid, ov);
      chk("fence_pulse", fence_pulse, fp);
      chk("exc_valid", exc_valid, ev);
      if (fp) chk("fence_i", fence_i, h.dec[5]);
      if (ov) begin
        chk("out_unit", out_unit, h.dec[4] ? 2'd2 : h.dec[14:13]);
        chk("out_sub_unit", out_sub_unit, h.dec[12:10]);
        chk("out_sel", out_sel, h.dec[9:6]);
        chk("out_use_imm", out_use_imm, h.dec[5]);
        chk("out_imm", out_imm, ref_imm(h.instr, h.dec[5]));
        chk("out_rs1", out_rs1, h.instr[19:15]);
        chk("out_rs2", out_rs2, h.instr[24:20]);
        chk("out_rd", out_rd, h.instr[11:7]);
        chk("out_pc", out_pc, h.pc);
      end
      if (ev) begin
        chk("exc_cause", exc_cause, cause);
        chk("exc_pc", exc_pc, h.pc);
      end
    end

    if (rst) begin
      q.delete(); mode = 0; rdy = 1'b0; live = 1'b1;
    end else if (fl) begin
      q.delete(); mode = 0; rdy = 1'b0;
    end else begin
      acc = iv && rdy;
      pop = (ov && ordy) || fp || (ev && ack);
      case (mode)
        0: if (ser) mode = 1;
        1: if (pe) mode = fen ? 0 : 2;
        default: if (ack) mode = 0;
      endcase
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{ins, pc, dec});
      rdy = (q.size() <= 1) && (mode == 0);
    end
  endtask

  task automatic idle(input bit ordy, input bit pe, input bit ack);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 15'h0, ordy, pe, ack, 1'b0);
  endtask

  initial begin
    checks = 0; failures = 0; live = 1'b0; mode = 0; rdy = 1'b0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_decode = '0;
    out_ready = 1'b0; pipe_empty = 1'b0; exc_ack = 1'b0;

    // Reset: in_ready low first, then high
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 32'h0, 15'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    chk("rst_in_ready_low", s_in_ready, 1'b0);
    chk("rst_out_valid", s_out_valid, 1'b0);
    chk("rst_exc_valid", s_exc, 1'b0);
    chk("rst_out_imm", s_imm, 32'h0);
    idle(1'b1, 1'b1, 1'b0);
    chk("rst_in_ready_high", s_in_ready, 1'b1);

    // ADDI x1,x0,5
    cycle(1'b0, 1'b1, 32'h00500093, 32'h100, 15'h0820, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    chk("addi_valid", s_out_valid, 1'b1);
    chk("addi_unit", s_unit, 2'd0);
    chk("addi_sub", s_sub, 3'd2);
    chk("addi_sel", s_sel, 4'd0);
    chk("addi_use_imm", s_use_imm, 1'b1);
    chk("addi_imm", s_imm, 32'd5);
    chk("addi_rd", s_rd, 5'd1);
    chk("addi_rs1", s_rs1, 5'd0);

    // SW x2,-4(x1)
    cycle(1'b0, 1'b1, 32'hFE20AE23, 32'h104, 15'h24A0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    chk("sw_unit", s_unit, 2'd1);
    chk("sw_sub", s_sub, 3'd1);
    chk("sw_sel", s_sel, 4'd2);
    chk("sw_imm", s_imm, 32'hFFFFFFFC);
    chk("sw_rs1", s_rs1, 5'd1);
    chk("sw_rs2", s_rs2, 5'd2);

    // BEQ x0,x0,-8
    cycle(1'b0, 1'b1, 32'hFE000CE3, 32'h108, 15'h0C00, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    chk("beq_imm", s_imm, 32'hFFFFFFF8);

    // Four ADDIs with out_ready low for the first three cycles
    sent = 0;
    issued.delete();
    for (int k = 0; k < 16; k++) begin
      ordy_k = (k >= 3);
      cycle(1'b0, sent < 4, 32'h00500013 | ({27'h0, 5'(sent + 1)} << 7), 32'h200 + 32'(4 * sent),
            15'h0820, ordy_k, 1'b1, 1'b0, 1'b0);
      if (k == 2) begin
        chk("stream_in_ready_drop", s_in_ready, 1'b0);
        chk("stream_hold_rd", s_rd, 5'd1);
      end
      if (s_acc) sent++;
      if (s_out_valid && ordy_k) issued.push_back(s_rd);
    end
    chk("stream_count", 64'(issued.size()), 64'd4);
    for (int i = 0; i < issued.size() && i < 4; i++) chk("stream_order", issued[i], 64'(i + 1));

    // ECALL behind a busy back end
    cycle(1'b0, 1'b1, 32'h00000073, 32'h300, 15'h0004, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      idle(1'b1, 1'b0, 1'b0);
      chk("ecall_wait", s_exc, 1'b0);
    end
    idle(1'b1, 1'b1, 1'b0);
    chk("ecall_drain", s_exc, 1'b0);
    idle(1'b1, 1'b1, 1'b1);
    chk("ecall_exc", s_exc, 1'b1);
    chk("ecall_cause", s_cause, 4'd11);
    chk("ecall_pc", s_exc_pc, 32'h300);
    idle(1'b1, 1'b1, 1'b0);
    chk("ecall_cleared", s_exc, 1'b0);

    // FENCE.I with an empty back end
    fp_cnt = 0; fi_cnt = 0; ov_cnt = 0;
    cycle(1'b0, 1'b1, 32'h0000100F, 32'h400, 15'h0028, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      idle(1'b1, 1'b1, 1'b0);
      if (s_fence) fp_cnt++;
      if (s_fence && s_fence_i) fi_cnt++;
      if (s_out_valid) ov_cnt++;
    end
    chk("fencei_pulses", 64'(fp_cnt), 64'd1);
    chk("fencei_qual", 64'(fi_cnt), 64'd1);
    chk("fencei_no_issue", 64'(ov_cnt), 64'd0);

    // Illegal word, then flush during the trap with a colliding input
    cycle(1'b0, 1'b1, 32'hFFFFFFFF, 32'h500, 15'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    chk("illegal_exc", s_exc, 1'b1);
    chk("illegal_cause", s_cause, 4'd2);
    chk("illegal_pc", s_exc_pc, 32'h500);
    cycle(1'b0, 1'b1, 32'h00500093, 32'h600, 15'h0820, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("flush_exc_now", s_exc, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    chk("flush_exc_next", s_exc, 1'b0);
    chk("flush_empty", s_out_valid, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    chk("flush_not_captured", s_out_valid, 1'b0);
    chk("flush_in_ready_back", s_in_ready, 1'b1);

    // Random traffic with occasional flush and one mid-run reset
    for (int n = 0; n < 3000; n++) begin
      cycle(n == 1500, $urandom_range(0, 9) < 7, rand_instr(), $urandom, rand_dec(),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
            $urandom_range(0, 49) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
